// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding,
// the combinational result bundle and small opcode classifiers.
package md_unit_pkg;

    // md_op encoding driven by the EX controller; 7 is reserved and behaves as NONE.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Full 64-bit result of a multiply or divide plus the divide-by-zero flag.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } md_result_t;

    // Multiply-class opcodes use the MULT_CYCLES latency.
    function automatic logic is_mult_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // Divide-class opcodes use the DIV_CYCLES latency.
    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Purely combinational arithmetic core: (rs, rt, op) -> {hi, lo, div0}.
// Signed division goes through magnitudes so that 0x80000000 / -1 wraps
// to 0x80000000 without relying on tool-specific overflow behaviour.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  md_op_e      op,
    output md_result_t  res
);

    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div0;
    logic [31:0] safe_b;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_signed   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_unsigned = {32'd0, rs} * {32'd0, rt};

    // Magnitude divider shared by DIV and DIVU; a zero divisor is replaced by 1 to keep outputs defined.
    assign signed_div = (op == MD_DIV);
    assign neg_a      = signed_div & rs[31];
    assign neg_b      = signed_div & rt[31];
    assign mag_a      = neg_a ? (32'd0 - rs) : rs;
    assign mag_b      = neg_b ? (32'd0 - rt) : rt;
    assign div0       = (rt == 32'd0);
    assign safe_b     = div0 ? 32'd1 : mag_b;
    assign quot_mag   = mag_a / safe_b;
    assign rem_mag    = mag_a % safe_b;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign quot       = (neg_a ^ neg_b) ? (32'd0 - quot_mag) : quot_mag;
    assign rem        = neg_a ? (32'd0 - rem_mag) : rem_mag;

    // Select the result for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        res = '0;
        case (op)
            MD_MULT:  {res.hi, res.lo} = prod_signed;
            MD_MULTU: {res.hi, res.lo} = prod_unsigned;
            MD_DIV, MD_DIVU: begin
                res.hi   = rem;
                res.lo   = quot;
                res.div0 = div0;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept time, parked in pending registers and
// committed to HI/LO after a fixed busy period; MTHI/MTLO write in one cycle.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_op_e      op;
    md_result_t  calc_res;
    logic [CNT_W-1:0] cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_div0;

    assign op = md_op_e'(md_op);

    md_calc u_calc (
        .rs  (rs_val),
        .rt  (rt_val),
        .op  (op),
        .res (calc_res)
    );

    // Accept, countdown and commit; start is ignored entirely while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            cnt       <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_div0 <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (busy) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end else begin
                busy <= 1'b0;
                if (!pend_div0) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else if (start) begin
            if (is_mult_op(op) || is_div_op(op)) begin
                pend_hi   <= calc_res.hi;
                pend_lo   <= calc_res.lo;
                pend_div0 <= calc_res.div0;
                cnt       <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                busy      <= 1'b1;
            end else if (op == MD_MTHI) begin
                hi <= rs_val;
            end else if (op == MD_MTLO) begin
                lo <= rs_val;
            end
        end
    end

    // mfhi/mflo read path into the EX result mux.
    assign md_out = rd_sel ? hi : lo;

endmodule
